// File: rtl/kyber_intt_pkg.sv
// kyber_intt_pkg: constants and state encoding shared by the INTT poly collector.
package kyber_intt_pkg;
    localparam int BEAT_W = 128;
    localparam int BEATS  = 32;
    localparam logic [1:0] SLOT_V   = 2'd0;
    localparam logic [1:0] SLOT_BP0 = 2'd1;
    localparam logic [1:0] SLOT_BP1 = 2'd2;
    localparam logic [6:0] ENC_LAST_AD = 7'd95;
    localparam logic [6:0] DEC_LAST_AD = 7'd31;
    typedef enum logic [2:0] {ST_IDLE, ST_ENC_COL, ST_DEC_SH1, ST_DEC_SH2, ST_DONE} state_e;
endpackage

// File: rtl/poly_beat_reg.sv
// poly_beat_reg: one polynomial register written a beat at a time, with sync clear.
// nxt_o is the value the register takes at the coming edge, so reads see same-edge writes.
module poly_beat_reg #(
    parameter int BEAT_W = 128,
    parameter int BEATS  = 32,
    parameter int OFF_W  = $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    we,
    input  logic [OFF_W-1:0]        off,
    input  logic [BEAT_W-1:0]       data,
    output logic [BEAT_W*BEATS-1:0] nxt_o
);
    logic [BEAT_W*BEATS-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = clr ? '0 : mem_q;
        if (we && !clr) mem_d[off*BEAT_W +: BEAT_W] = data;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign nxt_o = mem_d;
endmodule

// File: rtl/intt_poly_collector.sv
// intt_poly_collector: reassembles INTT write beats into V/Bp0/Bp1 (enc) or Mp shares (dec)
// and serves registered whole-polynomial reads.
module intt_poly_collector #(
    parameter int KYBER_N = 256,
    parameter int COEFF_W = 16,
    parameter int BEAT_W  = 128,
    parameter int POLY_W  = COEFF_W*KYBER_N,
    parameter int BEATS   = POLY_W/BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mux_enc_dec,
    input  logic              wr_valid,
    input  logic [6:0]        wr_ad,
    input  logic [BEAT_W-1:0] wr_data1,
    input  logic [BEAT_W-1:0] wr_data2,
    input  logic [1:0]        rd_ad,
    output logic [POLY_W-1:0] rd_data1,
    output logic [POLY_W-1:0] rd_data2,
    output logic [3:0]        poly_valid,
    output logic              collect_done,
    output logic              proto_err
);
    import kyber_intt_pkg::*;

    state_e            state_q, state_d;
    logic [6:0]        exp_ad_q, exp_ad_d;
    logic [3:0]        pv_q, pv_d, pv_set;
    logic              err_q, err_d, done_q, done_d;
    logic [POLY_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic              coll, acc, last, bad, we2;
    logic [6:0]        last_ad;
    logic [2:0]        we1;
    logic [POLY_W-1:0] nxt1 [3];
    logic [POLY_W-1:0] nxt2;

    for (genvar g = 0; g < 3; g++) begin : g_sh1
        assign we1[g] = acc && state_q != ST_DEC_SH2 && wr_ad[6:5] == 2'(g);
        poly_beat_reg #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_reg (
            .clk(clk), .rst(rst), .clr(start), .we(we1[g]),
            .off(wr_ad[4:0]), .data(wr_data1), .nxt_o(nxt1[g])
        );
    end

    poly_beat_reg #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_sh2 (
        .clk(clk), .rst(rst), .clr(start), .we(we2),
        .off(wr_ad[4:0]), .data(wr_data2), .nxt_o(nxt2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            exp_ad_q <= '0;
            pv_q     <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            rd1_q    <= '0;
            rd2_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_ad_q <= exp_ad_d;
            pv_q     <= pv_d;
            err_q    <= err_d;
            done_q   <= done_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
        end
    end

    always_comb begin
        state_d = start ? (mux_enc_dec ? ST_DEC_SH1 : ST_ENC_COL)
                : last  ? (state_q == ST_DEC_SH1 ? ST_DEC_SH2 : ST_DONE)
                : state_q;
    end

    // exp_ad never exceeds the mode's last address, so out-of-range beats fail the match
    always_comb begin
        coll     = state_q inside {ST_ENC_COL, ST_DEC_SH1, ST_DEC_SH2};
        acc      = coll && wr_valid && !start && wr_ad == exp_ad_q;
        last_ad  = state_q == ST_ENC_COL ? ENC_LAST_AD : DEC_LAST_AD;
        last     = acc && wr_ad == last_ad;
        bad      = wr_valid && !start && state_q != ST_IDLE && !acc;
        we2      = acc && state_q == ST_DEC_SH2;
        exp_ad_d = (start || last) ? '0 : exp_ad_q + 7'(acc);
        pv_set   = (acc && &wr_ad[4:0]) ? (state_q == ST_DEC_SH2 ? 4'b1000 : 4'b0001 << wr_ad[6:5]) : '0;
        pv_d     = start ? '0 : pv_q | pv_set;
        err_d    = !start && (err_q || bad);
        done_d   = last && state_q != ST_DEC_SH1;
        rd1_d    = rd_ad == 2'd0 ? nxt1[0] : rd_ad == 2'd1 ? nxt1[1] : rd_ad == 2'd2 ? nxt1[2] : '0;
        rd2_d    = rd_ad == SLOT_V ? nxt2 : '0;
    end

    assign rd_data1     = rd1_q;
    assign rd_data2     = rd2_q;
    assign poly_valid   = pv_q;
    assign collect_done = done_q;
    assign proto_err    = err_q;
endmodule
